ifu_fetch_buffer: RTL and testbench



---
 rtl/ifu_fetch_buffer_pkg.sv | 37 +++
 rtl/ifu_inst_fifo.sv | 66 ++++++
 rtl/ifu_fetch_buffer.sv | 156 +++++++++++++++
 tb/tb_ifu_fetch_buffer.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_fetch_buffer_pkg.sv
// Shared widths, FIFO entry layout and helpers for the IFU fetch buffer.
// IFU_ALIGN_CHECK_EN adds an address-error (adef) bit to every FIFO entry.
`ifndef LA64_INST_WIDTH
`define LA64_INST_WIDTH 32
`endif
`ifndef LA64_PC_WIDTH
`define LA64_PC_WIDTH 64
`endif
`ifndef IFU_RESET_PC
`define IFU_RESET_PC 64'h0000_0000_1c00_0000
`endif

package ifu_fetch_buffer_pkg;

    localparam int unsigned INST_W = `LA64_INST_WIDTH;
    localparam int unsigned PC_W   = `LA64_PC_WIDTH;
    localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

    typedef enum logic [1:0] {
        FETCH_RUN,
        FETCH_ADEF,
        FETCH_HALT
    } fetch_mode_e;

    typedef struct packed {
`ifdef IFU_ALIGN_CHECK_EN
        logic              adef;
`endif
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
    } fifo_entry_t;

    function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] pc);
        return {pc[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifu_inst_fifo.sv
// Synchronous FIFO with flush and occupancy count; head entry read straight from storage.
// The caller must not push while full.
module ifu_inst_fifo #(
    parameter int unsigned WIDTH = 96,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           head_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_push  = push_i && !flush_i;
        do_pop   = pop_i && (count_q != '0) && !flush_i;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/ifu_fetch_buffer.sv
// Fetch front end: owns the fetch PC, issues credit-limited imem requests, buffers
// in-order responses and drops stale ones after a redirect. Optional: IFU_ALIGN_CHECK_EN.
module ifu_fetch_buffer
    import ifu_fetch_buffer_pkg::*;
#(
    parameter int unsigned     DEPTH           = 4,
    parameter int unsigned     MAX_OUTSTANDING = 4,
    parameter logic [PC_W-1:0] RESET_PC        = `IFU_RESET_PC
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_redirect_vld,
    input  logic [63:0]                 i_redirect_pc,
    output logic                        o_imem_req_vld,
    output logic [63:0]                 o_imem_req_addr,
    input  logic                        i_imem_req_rdy,
    input  logic                        i_imem_resp_vld,
    input  logic [`LA64_INST_WIDTH-1:0] i_imem_resp_inst,
    output logic                        o_inst_vld,
    output logic [`LA64_INST_WIDTH-1:0] o_inst,
    output logic [63:0]                 o_inst_pc,
    input  logic                        i_inst_rdy,
    output logic                        o_inst_adef
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned SUM_W = ((CNT_W > OUT_W) ? CNT_W : OUT_W) + 1;

    logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0]  resp_pc_q, resp_pc_d;
    logic [OUT_W-1:0] outstanding_q, outstanding_d;
    logic [OUT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [OUT_W-1:0] in_flight;
    logic [CNT_W-1:0] fifo_count;
    logic             fetch_en, credit_ok, req_fire;
    logic             resp_accept, resp_keep;
    logic             fifo_push, fifo_pop;
    fifo_entry_t      push_entry, head_entry;

`ifdef IFU_ALIGN_CHECK_EN
    fetch_mode_e      mode_q, mode_d;
    logic [PC_W-1:0]  adef_pc_q, adef_pc_d;
    assign fetch_en = (mode_q == FETCH_RUN);
`else
    assign fetch_en = 1'b1;
`endif

    // Buffered plus still-expected kept words never exceed DEPTH, so pushes cannot overflow.
    assign in_flight   = outstanding_q + drop_cnt_q;
    assign credit_ok   = ((SUM_W'(fifo_count) + SUM_W'(outstanding_q)) < SUM_W'(DEPTH))
                      && (in_flight < OUT_W'(MAX_OUTSTANDING));
    assign o_imem_req_vld  = !i_rst && !i_redirect_vld && fetch_en && credit_ok;
    assign o_imem_req_addr = fetch_pc_q;
    assign req_fire    = o_imem_req_vld && i_imem_req_rdy;
    assign resp_accept = i_imem_resp_vld && (in_flight != '0);
    assign resp_keep   = resp_accept && (drop_cnt_q == '0);
    assign fifo_pop    = i_inst_rdy && !i_redirect_vld;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        fifo_push     = 1'b0;
        push_entry    = '0;
`ifdef IFU_ALIGN_CHECK_EN
        mode_d        = mode_q;
        adef_pc_d     = adef_pc_q;
`endif
        if (i_redirect_vld) begin
            fetch_pc_d    = word_align(i_redirect_pc);
            resp_pc_d     = word_align(i_redirect_pc);
            outstanding_d = '0;
            drop_cnt_d    = in_flight - OUT_W'(resp_accept);
`ifdef IFU_ALIGN_CHECK_EN
            if (i_redirect_pc[1:0] != 2'b00) begin
                mode_d    = FETCH_ADEF;
                adef_pc_d = i_redirect_pc;
            end else begin
                mode_d    = FETCH_RUN;
            end
`endif
        end else begin
            if (req_fire) fetch_pc_d = fetch_pc_q + PC_STEP;
            if (resp_accept && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - OUT_W'(1);
            if (resp_keep) begin
                fifo_push       = 1'b1;
                push_entry.inst = i_imem_resp_inst;
                push_entry.pc   = resp_pc_q;
                resp_pc_d       = resp_pc_q + PC_STEP;
            end
            outstanding_d = outstanding_q + OUT_W'(req_fire) - OUT_W'(resp_keep);
`ifdef IFU_ALIGN_CHECK_EN
            // Nothing is kept in flight after a redirect, so the marker owns the push slot.
            if (mode_q == FETCH_ADEF) begin
                fifo_push       = 1'b1;
                push_entry.adef = 1'b1;
                push_entry.inst = '0;
                push_entry.pc   = adef_pc_q;
                mode_d          = FETCH_HALT;
            end
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

`ifdef IFU_ALIGN_CHECK_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mode_q    <= FETCH_RUN;
            adef_pc_q <= '0;
        end else begin
            mode_q    <= mode_d;
            adef_pc_q <= adef_pc_d;
        end
    end
`endif

    ifu_inst_fifo #(
        .WIDTH ($bits(fifo_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (i_clk),
        .rst_i       (i_rst),
        .flush_i     (i_redirect_vld),
        .push_i      (fifo_push),
        .push_data_i (push_entry),
        .pop_i       (fifo_pop),
        .head_o      (head_entry),
        .count_o     (fifo_count)
    );

    assign o_inst_vld = !i_rst && (fifo_count != '0);
    assign o_inst     = head_entry.inst;
    assign o_inst_pc  = head_entry.pc;
`ifdef IFU_ALIGN_CHECK_EN
    assign o_inst_adef = head_entry.adef;
`else
    assign o_inst_adef = 1'b0;
`endif

endmodule

// File: tb/tb_ifu_fetch_buffer.sv
// Directed bench for ifu_fetch_buffer: a falling-edge memory model answers requests in
// order with programmable latency and logs accepted requests and consumed instructions.
`ifndef LA64_INST_WIDTH
`define LA64_INST_WIDTH 32
`endif

module tb_ifu_fetch_buffer;

    localparam int unsigned INST_W = `LA64_INST_WIDTH;
    localparam int unsigned DEPTH  = 4;
    localparam logic [63:0] RST_PC = 64'h0000_0000_1c00_0000;

    logic              clk = 1'b0;
    logic              rst;
    logic              redirect_vld;
    logic [63:0]       redirect_pc;
    logic              req_vld;
    logic [63:0]       req_addr;
    logic              req_rdy;
    logic              resp_vld;
    logic [INST_W-1:0] resp_inst;
    logic              inst_vld;
    logic [INST_W-1:0] inst;
    logic [63:0]       inst_pc;
    logic              inst_rdy;
    logic              inst_adef;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int unsigned lat_min = 1, lat_max = 1;
    logic [63:0]       mem_addr_q[$];
    int unsigned       mem_due_q[$];
    logic [63:0]       req_log[$];
    logic [63:0]       pop_pc[$];
    logic [INST_W-1:0] pop_inst[$];
    logic              pop_adef[$];
    logic [63:0]       base;

    ifu_fetch_buffer #(
        .DEPTH           (DEPTH),
        .MAX_OUTSTANDING (4),
        .RESET_PC        (RST_PC)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_redirect_vld   (redirect_vld),
        .i_redirect_pc    (redirect_pc),
        .o_imem_req_vld   (req_vld),
        .o_imem_req_addr  (req_addr),
        .i_imem_req_rdy   (req_rdy),
        .i_imem_resp_vld  (resp_vld),
        .i_imem_resp_inst (resp_inst),
        .o_inst_vld       (inst_vld),
        .o_inst           (inst),
        .o_inst_pc        (inst_pc),
        .i_inst_rdy       (inst_rdy),
        .o_inst_adef      (inst_adef)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [INST_W-1:0] mem_word(input logic [63:0] a);
        return INST_W'(a ^ 64'h0000_0000_a5a5_0f0f);
    endfunction

    // Memory model and logger; all DUT inputs are settled by the falling edge.
    initial begin
        resp_vld  = 1'b0;
        resp_inst = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mem_addr_q.delete();
                mem_due_q.delete();
                resp_vld = 1'b0;
            end else begin
                if (mem_due_q.size() != 0 && mem_due_q[0] <= cyc) begin
                    resp_vld  = 1'b1;
                    resp_inst = mem_word(mem_addr_q[0]);
                    void'(mem_addr_q.pop_front());
                    void'(mem_due_q.pop_front());
                end else begin
                    resp_vld  = 1'b0;
                    resp_inst = '0;
                end
                if (req_vld && req_rdy) begin
                    mem_addr_q.push_back(req_addr);
                    mem_due_q.push_back(cyc + $urandom_range(lat_max, lat_min));
                    req_log.push_back(req_addr);
                end
                if (inst_vld && inst_rdy && !redirect_vld) begin
                    pop_pc.push_back(inst_pc);
                    pop_inst.push_back(inst);
                    pop_adef.push_back(inst_adef);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        req_log.delete();
        pop_pc.delete();
        pop_inst.delete();
        pop_adef.delete();
    endtask

    task automatic quiesce();
        bit done = 1'b0;
        req_rdy  = 1'b0;
        inst_rdy = 1'b1;
        for (int n = 0; n < 64 && !done; n++) begin
            tick();
            if (mem_addr_q.size() == 0 && !resp_vld && !inst_vld) done = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL quiesce_timeout inst_vld=%b pending=%0d required drained", inst_vld, mem_addr_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; redirect_vld = 1'b0; redirect_pc = '0; req_rdy = 1'b0; inst_rdy = 1'b0;
        repeat (3) tick();
        checks++;
        if (req_vld !== 1'b0) begin errors++; $display("FAIL reset_req_vld got %b exp 0", req_vld); end
        checks++;
        if (inst_vld !== 1'b0) begin errors++; $display("FAIL reset_inst_vld got %b exp 0", inst_vld); end
        rst = 1'b0;
        #1;
        checks++;
        if (req_vld !== 1'b1) begin errors++; $display("FAIL post_reset_req_vld got %b exp 1", req_vld); end
        checks++;
        if (req_addr !== RST_PC) begin errors++; $display("FAIL post_reset_addr got %h exp %h", req_addr, RST_PC); end
        tick();
        checks++;
        if (inst_vld !== 1'b0) begin errors++; $display("FAIL idle_inst_vld got %b exp 0", inst_vld); end
    endtask

    task automatic test_sequential();
        clear_logs();
        lat_min = 1; lat_max = 1;
        req_rdy = 1'b1; inst_rdy = 1'b1;
        tick();
        checks++;
        if (req_addr !== RST_PC + 64'd4) begin errors++; $display("FAIL seq_addr1 got %h exp %h", req_addr, RST_PC + 64'd4); end
        @(negedge clk); #1;
        checks++;
        if (resp_vld !== 1'b1 || inst_vld !== 1'b0) begin
            errors++; $display("FAIL seq_no_comb_path resp_vld=%b inst_vld=%b exp 1/0", resp_vld, inst_vld);
        end
        @(posedge clk); #1;
        checks++;
        if (inst_vld !== 1'b1 || inst_pc !== RST_PC || inst !== mem_word(RST_PC)) begin
            errors++; $display("FAIL seq_first_inst vld=%b pc=%h inst=%h exp 1/%h/%h", inst_vld, inst_pc, inst, RST_PC, mem_word(RST_PC));
        end
        repeat (20) tick();
        quiesce();
        checks++;
        if (req_log.size() < 10 || pop_pc.size() != req_log.size()) begin
            errors++; $display("FAIL seq_counts reqs=%0d pops=%0d exp >=10 and equal", req_log.size(), pop_pc.size());
        end
        for (int i = 0; i < req_log.size(); i++) begin
            checks++;
            if (req_log[i] !== RST_PC + 64'(4 * i)) begin errors++; $display("FAIL seq_req[%0d] got %h exp %h", i, req_log[i], RST_PC + 64'(4 * i)); end
        end
        for (int i = 0; i < pop_pc.size(); i++) begin
            checks++;
            if (pop_pc[i] !== RST_PC + 64'(4 * i) || pop_inst[i] !== mem_word(RST_PC + 64'(4 * i))) begin
                errors++; $display("FAIL seq_pop[%0d] pc=%h inst=%h exp %h", i, pop_pc[i], pop_inst[i], RST_PC + 64'(4 * i));
            end
        end
        base = RST_PC + 64'(4 * req_log.size());
    endtask

    task automatic test_backpressure();
        clear_logs();
        lat_min = 1; lat_max = 1;
        inst_rdy = 1'b0; req_rdy = 1'b1;
        repeat (12) tick();
        checks++;
        if (req_log.size() != DEPTH) begin errors++; $display("FAIL bp_req_count got %0d exp %0d", req_log.size(), DEPTH); end
        checks++;
        if (req_vld !== 1'b0) begin errors++; $display("FAIL bp_req_vld got %b exp 0", req_vld); end
        checks++;
        if (inst_vld !== 1'b1 || inst_pc !== base) begin errors++; $display("FAIL bp_head vld=%b pc=%h exp 1/%h", inst_vld, inst_pc, base); end
        inst_rdy = 1'b1;
        repeat (15) tick();
        quiesce();
        checks++;
        if (req_log.size() <= DEPTH || pop_pc.size() != req_log.size()) begin
            errors++; $display("FAIL bp_resume reqs=%0d pops=%0d exp >%0d and equal", req_log.size(), pop_pc.size(), DEPTH);
        end
        for (int i = 0; i < pop_pc.size(); i++) begin
            checks++;
            if (pop_pc[i] !== base + 64'(4 * i) || pop_inst[i] !== mem_word(base + 64'(4 * i))) begin
                errors++; $display("FAIL bp_pop[%0d] pc=%h exp %h", i, pop_pc[i], base + 64'(4 * i));
            end
        end
    endtask

    task automatic test_redirect();
        clear_logs();
        lat_min = 5; lat_max = 5;
        inst_rdy = 1'b1; req_rdy = 1'b1;
        repeat (3) tick();
        req_rdy = 1'b1;
        checks++;
        if (req_log.size() != 3) begin errors++; $display("FAIL redir_inflight got %0d exp 3", req_log.size()); end
        redirect_vld = 1'b1; redirect_pc = 64'h0000_0000_1c00_0100;
        #1;
        checks++;
        if (req_vld !== 1'b0) begin errors++; $display("FAIL redir_req_blocked got %b exp 0", req_vld); end
        tick();
        redirect_vld = 1'b0;
        checks++;
        if (inst_vld !== 1'b0) begin errors++; $display("FAIL redir_empty got %b exp 0", inst_vld); end
        lat_min = 1; lat_max = 1;
        repeat (25) tick();
        quiesce();
        checks++;
        if (req_log.size() < 4 || req_log[3] !== 64'h1c00_0100) begin
            errors++; $display("FAIL redir_first_req reqs=%0d exp addr 1c000100 at index 3", req_log.size());
        end
        checks++;
        if (pop_pc.size() == 0 || pop_pc.size() != req_log.size() - 3) begin
            errors++; $display("FAIL redir_pop_count got %0d exp %0d", pop_pc.size(), req_log.size() - 3);
        end
        for (int i = 0; i < pop_pc.size(); i++) begin
            checks++;
            if (pop_pc[i] !== 64'h1c00_0100 + 64'(4 * i) || pop_inst[i] !== mem_word(64'h1c00_0100 + 64'(4 * i))) begin
                errors++; $display("FAIL redir_pop[%0d] pc=%h exp %h", i, pop_pc[i], 64'h1c00_0100 + 64'(4 * i));
            end
        end
    endtask

    task automatic test_redirect_coincident();
        lat_min = 2; lat_max = 2;
        inst_rdy = 1'b1; req_rdy = 1'b1;
        repeat (10) tick();
        clear_logs();
        redirect_vld = 1'b1; redirect_pc = 64'h0000_0000_1c00_0300;
        @(negedge clk); #1;
        checks++;
        if (resp_vld !== 1'b1 || inst_vld !== 1'b1) begin
            errors++; $display("FAIL coinc_setup resp_vld=%b inst_vld=%b exp 1/1", resp_vld, inst_vld);
        end
        @(posedge clk); #1;
        redirect_vld = 1'b0;
        checks++;
        if (inst_vld !== 1'b0) begin errors++; $display("FAIL coinc_empty got %b exp 0", inst_vld); end
        lat_min = 1; lat_max = 1;
        repeat (20) tick();
        quiesce();
        checks++;
        if (pop_pc.size() == 0 || pop_pc.size() != req_log.size()) begin
            errors++; $display("FAIL coinc_pop_count pops=%0d reqs=%0d exp equal nonzero", pop_pc.size(), req_log.size());
        end
        for (int i = 0; i < pop_pc.size(); i++) begin
            checks++;
            if (pop_pc[i] !== 64'h1c00_0300 + 64'(4 * i) || pop_inst[i] !== mem_word(64'h1c00_0300 + 64'(4 * i))) begin
                errors++; $display("FAIL coinc_pop[%0d] pc=%h exp %h", i, pop_pc[i], 64'h1c00_0300 + 64'(4 * i));
            end
        end
    endtask

    task automatic test_back_to_back();
        lat_min = 3; lat_max = 3;
        inst_rdy = 1'b1; req_rdy = 1'b1;
        repeat (8) tick();
        clear_logs();
        redirect_vld = 1'b1; redirect_pc = 64'h0000_0000_1c00_0400;
        tick();
        redirect_pc = 64'h0000_0000_1c00_0500;
        tick();
        redirect_vld = 1'b0;
        checks++;
        if (inst_vld !== 1'b0) begin errors++; $display("FAIL b2b_empty got %b exp 0", inst_vld); end
        lat_min = 1; lat_max = 1;
        repeat (25) tick();
        quiesce();
        checks++;
        if (req_log.size() == 0 || req_log[0] !== 64'h1c00_0500) begin
            errors++; $display("FAIL b2b_first_req reqs=%0d exp first addr 1c000500", req_log.size());
        end
        checks++;
        if (pop_pc.size() == 0 || pop_pc.size() != req_log.size()) begin
            errors++; $display("FAIL b2b_pop_count pops=%0d reqs=%0d exp equal nonzero", pop_pc.size(), req_log.size());
        end
        for (int i = 0; i < pop_pc.size(); i++) begin
            checks++;
            if (pop_pc[i] !== 64'h1c00_0500 + 64'(4 * i)) begin
                errors++; $display("FAIL b2b_pop[%0d] pc=%h exp %h", i, pop_pc[i], 64'h1c00_0500 + 64'(4 * i));
            end
        end
    endtask

    task automatic test_misaligned();
`ifdef IFU_ALIGN_CHECK_EN
        clear_logs();
        lat_min = 1; lat_max = 1;
        inst_rdy = 1'b0; req_rdy = 1'b1;
        redirect_vld = 1'b1; redirect_pc = 64'h0000_0000_1c00_0102;
        tick();
        redirect_vld = 1'b0;
        tick();
        checks++;
        if (inst_vld !== 1'b1 || inst_adef !== 1'b1 || inst_pc !== 64'h1c00_0102 || inst !== '0) begin
            errors++; $display("FAIL adef_entry vld=%b adef=%b pc=%h inst=%h exp 1/1/1c000102/0", inst_vld, inst_adef, inst_pc, inst);
        end
        inst_rdy = 1'b1;
        repeat (10) tick();
        checks++;
        if (req_log.size() != 0 || req_vld !== 1'b0 || inst_vld !== 1'b0) begin
            errors++; $display("FAIL adef_halt reqs=%0d req_vld=%b inst_vld=%b exp 0/0/0", req_log.size(), req_vld, inst_vld);
        end
        checks++;
        if (pop_pc.size() != 1) begin errors++; $display("FAIL adef_pop_count got %0d exp 1", pop_pc.size()); end
        clear_logs();
        redirect_vld = 1'b1; redirect_pc = 64'h0000_0000_1c00_0200;
        tick();
        redirect_vld = 1'b0;
        base = 64'h0000_0000_1c00_0200;
`else
        clear_logs();
        lat_min = 1; lat_max = 1;
        inst_rdy = 1'b1; req_rdy = 1'b1;
        redirect_vld = 1'b1; redirect_pc = 64'h0000_0000_1c00_0602;
        tick();
        redirect_vld = 1'b0;
        base = 64'h0000_0000_1c00_0600;
`endif
        req_rdy = 1'b1;
        repeat (15) tick();
        quiesce();
        checks++;
        if (pop_pc.size() == 0 || pop_pc.size() != req_log.size()) begin
            errors++; $display("FAIL align_pop_count pops=%0d reqs=%0d exp equal nonzero", pop_pc.size(), req_log.size());
        end
        for (int i = 0; i < pop_pc.size(); i++) begin
            checks++;
            if (pop_pc[i] !== base + 64'(4 * i) || pop_adef[i] !== 1'b0) begin
                errors++; $display("FAIL align_pop[%0d] pc=%h adef=%b exp %h/0", i, pop_pc[i], pop_adef[i], base + 64'(4 * i));
            end
        end
    endtask

    task automatic test_random();
        int max_live = 0;
        int live;
        bit got_all = 1'b0;
        base = 64'h0000_0000_1c00_1000;
        clear_logs();
        redirect_vld = 1'b1; redirect_pc = base;
        tick();
        redirect_vld = 1'b0;
        lat_min = 1; lat_max = 5;
        for (int n = 0; n < 20000 && !got_all; n++) begin
            req_rdy  = 1'($urandom_range(1, 0));
            inst_rdy = ($urandom_range(3, 0) != 0);
            tick();
            live = req_log.size() - pop_pc.size();
            if (live > max_live) max_live = live;
            if (pop_pc.size() >= 1000) got_all = 1'b1;
        end
        quiesce();
        checks++;
        if (!got_all) begin errors++; $display("FAIL rand_budget pops=%0d exp >=1000", pop_pc.size()); end
        checks++;
        if (max_live > DEPTH) begin errors++; $display("FAIL rand_occupancy got %0d exp <=%0d", max_live, DEPTH); end
        checks++;
        if (pop_pc.size() != req_log.size()) begin
            errors++; $display("FAIL rand_no_loss pops=%0d reqs=%0d exp equal", pop_pc.size(), req_log.size());
        end
        for (int i = 0; i < pop_pc.size(); i++) begin
            checks++;
            if (pop_pc[i] !== base + 64'(4 * i) || pop_inst[i] !== mem_word(base + 64'(4 * i))) begin
                errors++; $display("FAIL rand_pop[%0d] pc=%h inst=%h exp %h", i, pop_pc[i], pop_inst[i], base + 64'(4 * i));
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect();
        test_redirect_coincident();
        test_back_to_back();
        test_misaligned();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
